// File: rtl/csi_rx_pkg.sv
// Shared CSI-2 receive definitions: data types, header layout, ECC syndrome columns
// and the packet handler FSM state encoding.
package csi_rx_pkg;

  localparam logic [5:0] DT_FS       = 6'h00;
  localparam logic [5:0] DT_FE       = 6'h01;
  localparam logic [5:0] DT_LS       = 6'h02;
  localparam logic [5:0] DT_LE       = 6'h03;
  localparam logic [5:0] DT_RAW8     = 6'h2A;
  localparam logic [5:0] DT_RAW10    = 6'h2B;
  localparam logic [5:0] LONG_DT_MIN = 6'h10;

  // Parity contribution {P5..P0} of header data bit k; also the syndrome of a flip of bit k.
  localparam logic [23:0][5:0] ECC_COL = {
    6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
    6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
    6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07
  };

  typedef struct packed {
    logic [5:0]  dt;
    logic [1:0]  vc;
    logic [15:0] wc;
  } hdr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_t;

endpackage

// File: rtl/csi_rx_packet_handler_if.sv
// Stream interface between the lane merger, the packet handler and the pixel unpacker.
// Handshake: no backpressure; a word is accepted on any clk edge where in_valid is high.
interface csi_rx_packet_handler_if;
  import csi_rx_pkg::*;

  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;

  logic        hdr_valid;
  logic [5:0]  hdr_dt;
  logic [1:0]  hdr_vc;
  logic [15:0] hdr_wc;
  logic        hdr_short;
  logic        hdr_corrected;
  logic        hdr_err;

  logic [31:0] pay_data;
  logic        pay_valid;
  logic [3:0]  pay_be;
  logic        pay_last;

  logic        pkt_end;
  logic [15:0] rx_crc;
  logic        pkt_abort;

  state_t      dbg_state;

  modport master (
    output in_data, in_valid, in_sop,
    input  hdr_valid, hdr_dt, hdr_vc, hdr_wc, hdr_short, hdr_corrected, hdr_err,
    input  pay_data, pay_valid, pay_be, pay_last, pkt_end, rx_crc, pkt_abort, dbg_state
  );

  modport slave (
    input  in_data, in_valid, in_sop,
    output hdr_valid, hdr_dt, hdr_vc, hdr_wc, hdr_short, hdr_corrected, hdr_err,
    output pay_data, pay_valid, pay_be, pay_last, pkt_end, rx_crc, pkt_abort, dbg_state
  );

endinterface

// File: rtl/csi_rx_hdr_ecc.sv
// CSI-2 packet header ECC generator: 6 parity bits over the 24 header data bits, P7/P6 = 0.
module csi_rx_hdr_ecc
  import csi_rx_pkg::*;
(
  input  logic [23:0] data,
  output logic [7:0]  ecc
);

  always_comb begin
    ecc = 8'h00;
    for (int k = 0; k < 24; k++) begin
      if (data[k]) ecc[5:0] = ecc[5:0] ^ ECC_COL[k];
    end
  end

endmodule

// File: rtl/csi_rx_packet_handler.sv
// CSI-2 packet handler: header ECC check/correct, DI/WC decode, payload streaming, CRC strip.
// Define CSI_RX_HDR_CORRECT_EN to enable single-bit header correction.
module csi_rx_packet_handler
  import csi_rx_pkg::*;
#(
  parameter logic [15:0] MAX_WC = 16'd8192
) (
  input logic                     clk,
  input logic                     rst_n,
  csi_rx_packet_handler_if.slave  rx
);

  state_t      state;
  logic [16:0] rem;        // packet bytes (payload + CRC) still expected
  logic [15:0] pay_left;   // payload bytes still expected
  logic [7:0]  crc_lo;
  logic        crc_have;

  logic [7:0]  calc_ecc;
  logic [5:0]  syndrome;
  logic [23:0] fixed;
  logic        hdr_ok;
  logic        hdr_fix;
  hdr_t        hdr;
  logic        hdr_long;
  logic        wc_bad;

  logic [2:0]  take;
  logic [2:0]  pay_n;
  logic [2:0]  crc_n;
  logic [3:0]  be;
  logic [31:0] be_mask;
  logic [31:0] crc_word;

  logic        unused_bits;
  assign unused_bits = ^{rx.in_data[31:30], calc_ecc[7:6], crc_word[31:16]};

  csi_rx_hdr_ecc u_ecc (
    .data (rx.in_data[23:0]),
    .ecc  (calc_ecc)
  );

  always_comb begin
    syndrome = calc_ecc[5:0] ^ rx.in_data[29:24];
    fixed    = rx.in_data[23:0];
    hdr_ok   = (syndrome == 6'd0);
    hdr_fix  = 1'b0;
`ifdef CSI_RX_HDR_CORRECT_EN
    // One-hot syndrome means the ECC byte itself took the hit; data is already good.
    if (syndrome != 6'd0) begin
      if ($onehot(syndrome)) begin
        hdr_ok  = 1'b1;
        hdr_fix = 1'b1;
      end
      for (int k = 0; k < 24; k++) begin
        if (ECC_COL[k] == syndrome) begin
          fixed[k] = ~fixed[k];
          hdr_ok   = 1'b1;
          hdr_fix  = 1'b1;
        end
      end
    end
`endif
    hdr.dt   = fixed[5:0];
    hdr.vc   = fixed[7:6];
    hdr.wc   = fixed[23:8];
    hdr_long = (hdr.dt >= LONG_DT_MIN);
    wc_bad   = hdr_long && (hdr.wc > MAX_WC);
  end

  always_comb begin
    take     = (rem >= 17'd4) ? 3'd4 : rem[2:0];
    pay_n    = (pay_left >= 16'd4) ? 3'd4 : pay_left[2:0];
    crc_n    = take - pay_n;
    // CRC bytes start right after the last payload byte of the word.
    crc_word = rx.in_data >> {pay_n[1:0], 3'b000};
    case (pay_n)
      3'd0:    be = 4'h0;
      3'd1:    be = 4'h1;
      3'd2:    be = 4'h3;
      3'd3:    be = 4'h7;
      default: be = 4'hF;
    endcase
    be_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      rem              <= '0;
      pay_left         <= '0;
      crc_lo           <= '0;
      crc_have         <= 1'b0;
      rx.hdr_valid     <= 1'b0;
      rx.hdr_dt        <= '0;
      rx.hdr_vc        <= '0;
      rx.hdr_wc        <= '0;
      rx.hdr_short     <= 1'b0;
      rx.hdr_corrected <= 1'b0;
      rx.hdr_err       <= 1'b0;
      rx.pay_data      <= '0;
      rx.pay_valid     <= 1'b0;
      rx.pay_be        <= '0;
      rx.pay_last      <= 1'b0;
      rx.pkt_end       <= 1'b0;
      rx.rx_crc        <= '0;
      rx.pkt_abort     <= 1'b0;
    end else begin
      rx.hdr_valid     <= 1'b0;
      rx.hdr_short     <= 1'b0;
      rx.hdr_corrected <= 1'b0;
      rx.hdr_err       <= 1'b0;
      rx.pay_valid     <= 1'b0;
      rx.pay_last      <= 1'b0;
      rx.pkt_end       <= 1'b0;
      rx.pkt_abort     <= 1'b0;

      if (rx.in_valid && rx.in_sop) begin
        // A header always wins: a packet in flight is abandoned without pkt_end.
        if (state == ST_BODY) rx.pkt_abort <= 1'b1;
        state    <= ST_IDLE;
        crc_have <= 1'b0;
        if (!hdr_ok || wc_bad) begin
          rx.hdr_err <= 1'b1;
        end else begin
          rx.hdr_valid     <= 1'b1;
          rx.hdr_dt        <= hdr.dt;
          rx.hdr_vc        <= hdr.vc;
          rx.hdr_wc        <= hdr.wc;
          rx.hdr_short     <= !hdr_long;
          rx.hdr_corrected <= hdr_fix;
          if (hdr_long) begin
            state    <= ST_BODY;
            rem      <= {1'b0, hdr.wc} + 17'd2;
            pay_left <= hdr.wc;
          end
        end
      end else if (rx.in_valid && state == ST_BODY) begin
        rem      <= rem - 17'(take);
        pay_left <= pay_left - 16'(pay_n);
        if (pay_n != 3'd0) begin
          rx.pay_valid <= 1'b1;
          rx.pay_data  <= rx.in_data & be_mask;
          rx.pay_be    <= be;
          rx.pay_last  <= (pay_left <= 16'd4);
        end
        if (crc_have) begin
          rx.rx_crc  <= {rx.in_data[7:0], crc_lo};
          rx.pkt_end <= 1'b1;
          crc_have   <= 1'b0;
          state      <= ST_IDLE;
        end else if (crc_n == 3'd2) begin
          rx.rx_crc  <= crc_word[15:0];
          rx.pkt_end <= 1'b1;
          state      <= ST_IDLE;
        end else if (crc_n == 3'd1) begin
          // wc mod 4 == 3: CRC low byte rides in byte3, high byte comes next word.
          crc_lo   <= crc_word[7:0];
          crc_have <= 1'b1;
        end
      end
    end
  end

  assign rx.dbg_state = state;

endmodule

// File: tb/tb_csi_rx_packet_handler.sv
// Bench for csi_rx_packet_handler: vector table, directed multi-cycle sequences and
// randomized packets checked against a byte-position reference model.
module tb_csi_rx_packet_handler;
  import csi_rx_pkg::*;

`ifdef CSI_RX_HDR_CORRECT_EN
  localparam bit CORR_EN = 1'b1;
`else
  localparam bit CORR_EN = 1'b0;
`endif
  localparam int MAX_WC = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csi_rx_packet_handler_if bus ();

  csi_rx_packet_handler #(.MAX_WC(16'd8192)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (bus)
  );

  typedef struct {
    bit hv; logic [5:0] dt; logic [1:0] vc; logic [15:0] wc; bit shrt; bit corr; bit err;
    bit pv; logic [31:0] pd; logic [3:0] be; bit last; bit pend; logic [15:0] crc; bit abort;
  } exp_t;

  typedef struct {
    bit v; bit s; logic [31:0] d;
    bit hv; bit err; bit corr; bit pv; logic [3:0] be; bit last; bit pend; logic [15:0] crc;
  } vec_t;

  int n_tests = 0;
  int n_fail = 0;
  int pv_cnt = 0;
  int end_cnt = 0;

  // reference model state: packet position in bytes
  bit         m_in_pkt = 1'b0;
  int         m_wc = 0;
  int         m_pos = 0;
  logic [7:0] m_lo = 8'h00;

  function automatic logic [5:0] col(int k);
    case (k)
      0: return 6'h07;  1: return 6'h0B;  2: return 6'h0D;  3: return 6'h0E;
      4: return 6'h13;  5: return 6'h15;  6: return 6'h16;  7: return 6'h19;
      8: return 6'h1A;  9: return 6'h1C; 10: return 6'h23; 11: return 6'h25;
     12: return 6'h26; 13: return 6'h29; 14: return 6'h2A; 15: return 6'h2C;
     16: return 6'h31; 17: return 6'h32; 18: return 6'h34; 19: return 6'h38;
     20: return 6'h1F; 21: return 6'h2F; 22: return 6'h37; 23: return 6'h3B;
      default: return 6'h00;
    endcase
  endfunction

  function automatic logic [5:0] ecc_of(logic [23:0] d);
    logic [5:0] e = 6'h00;
    for (int k = 0; k < 24; k++) if (d[k]) e ^= col(k);
    return e;
  endfunction

  function automatic logic [31:0] mk_hdr(logic [5:0] dt, logic [1:0] vc, logic [15:0] wc);
    logic [23:0] d = {wc, vc, dt};
    return {2'b00, ecc_of(d), d};
  endfunction

  function automatic vec_t mkv(bit v, bit s, logic [31:0] d, bit hv, bit err, bit corr,
                               bit pv, logic [3:0] be, bit last, bit pend, logic [15:0] crc);
    vec_t r;
    r.v = v; r.s = s; r.d = d; r.hv = hv; r.err = err; r.corr = corr;
    r.pv = pv; r.be = be; r.last = last; r.pend = pend; r.crc = crc;
    return r;
  endfunction

  function automatic void model_step(bit v, bit s, logic [31:0] data, output exp_t e);
    logic [23:0] fixed;
    logic [5:0]  syn;
    bit          ok;
    int          q;
    e = '{default: '0};
    if (!v) return;
    if (s) begin
      if (m_in_pkt) e.abort = 1'b1;
      m_in_pkt = 1'b0;
      fixed = data[23:0];
      syn   = ecc_of(fixed) ^ data[29:24];
      ok    = (syn == 6'h00);
      if (!ok && CORR_EN) begin
        if ($countones(syn) == 1) begin
          ok = 1'b1; e.corr = 1'b1;
        end else begin
          for (int k = 0; k < 24; k++) begin
            if (col(k) == syn) begin fixed[k] = ~fixed[k]; ok = 1'b1; e.corr = 1'b1; end
          end
        end
      end
      if (ok && fixed[5:0] >= 6'h10 && int'(fixed[23:8]) > MAX_WC) ok = 1'b0;
      if (!ok) begin
        e.err = 1'b1; e.corr = 1'b0;
      end else begin
        e.hv = 1'b1; e.dt = fixed[5:0]; e.vc = fixed[7:6]; e.wc = fixed[23:8];
        e.shrt = (fixed[5:0] < 6'h10);
        if (!e.shrt) begin m_in_pkt = 1'b1; m_wc = int'(fixed[23:8]); m_pos = 0; end
      end
    end else if (m_in_pkt) begin
      for (int i = 0; i < 4; i++) begin
        q = m_pos + i;
        if (q < m_wc) begin
          e.pv = 1'b1; e.be[i] = 1'b1; e.pd[8*i +: 8] = data[8*i +: 8];
          if (q == m_wc - 1) e.last = 1'b1;
        end else if (q == m_wc) begin
          m_lo = data[8*i +: 8];
        end else if (q == m_wc + 1) begin
          e.crc = {data[8*i +: 8], m_lo}; e.pend = 1'b1;
        end
      end
      m_pos += 4;
      if (e.pend) m_in_pkt = 1'b0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a negedge: drive one cycle, sample the registered result at the next negedge.
  task automatic step(input bit v, input bit s, input logic [31:0] d);
    exp_t e;
    bus.in_valid = v; bus.in_sop = s; bus.in_data = d;
    model_step(v, s, d, e);
    @(negedge clk);
    pv_cnt  += int'(bus.pay_valid);
    end_cnt += int'(bus.pkt_end);
    check("hdr_valid", 32'(bus.hdr_valid), 32'(e.hv));
    check("hdr_err", 32'(bus.hdr_err), 32'(e.err));
    check("hdr_corrected", 32'(bus.hdr_corrected), 32'(e.corr));
    check("pay_valid", 32'(bus.pay_valid), 32'(e.pv));
    check("pkt_end", 32'(bus.pkt_end), 32'(e.pend));
    check("pkt_abort", 32'(bus.pkt_abort), 32'(e.abort));
    if (e.hv) begin
      check("hdr_dt", 32'(bus.hdr_dt), 32'(e.dt));
      check("hdr_vc", 32'(bus.hdr_vc), 32'(e.vc));
      check("hdr_wc", 32'(bus.hdr_wc), 32'(e.wc));
      check("hdr_short", 32'(bus.hdr_short), 32'(e.shrt));
    end
    if (e.pv) begin
      check("pay_data", bus.pay_data, e.pd);
      check("pay_be", 32'(bus.pay_be), 32'(e.be));
      check("pay_last", 32'(bus.pay_last), 32'(e.last));
    end
    if (e.pend) check("rx_crc", 32'(bus.rx_crc), 32'(e.crc));
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom_range(0, 1)), $urandom);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hdr_valid"}, 32'(bus.hdr_valid), 0);
    check({tag, "_hdr_dt"}, 32'(bus.hdr_dt), 0);
    check({tag, "_hdr_vc"}, 32'(bus.hdr_vc), 0);
    check({tag, "_hdr_wc"}, 32'(bus.hdr_wc), 0);
    check({tag, "_hdr_short"}, 32'(bus.hdr_short), 0);
    check({tag, "_hdr_corrected"}, 32'(bus.hdr_corrected), 0);
    check({tag, "_hdr_err"}, 32'(bus.hdr_err), 0);
    check({tag, "_pay_data"}, bus.pay_data, 0);
    check({tag, "_pay_valid"}, 32'(bus.pay_valid), 0);
    check({tag, "_pay_be"}, 32'(bus.pay_be), 0);
    check({tag, "_pay_last"}, 32'(bus.pay_last), 0);
    check({tag, "_pkt_end"}, 32'(bus.pkt_end), 0);
    check({tag, "_rx_crc"}, 32'(bus.rx_crc), 0);
    check({tag, "_pkt_abort"}, 32'(bus.pkt_abort), 0);
    check({tag, "_state"}, 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  // Entered at a negedge; asserts reset asynchronously and leaves at a negedge.
  task automatic do_reset(input string tag);
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_data = '0;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
    m_in_pkt = 1'b0;
  endtask

  vec_t        tbl[12];
  logic [31:0] w;
  logic [31:0] hw;
  logic [5:0]  dt;
  logic [15:0] wc;
  int          nwords;

  initial begin
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_data = '0;
    #1 check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mkv(1, 1, 32'h1A000100, 1, 0, 0, 0, 4'h0, 0, 0, 16'h0);       // FS
    tbl[1]  = mkv(1, 1, 32'h1D000101, 1, 0, 0, 0, 4'h0, 0, 0, 16'h0);       // FE back-to-back
    tbl[2]  = mkv(0, 0, 32'h00000000, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0);
    tbl[3]  = mkv(1, 1, 32'h0E028029, 0, 1, 0, 0, 4'h0, 0, 0, 16'h0);       // S = 0x0C
    tbl[4]  = mkv(1, 0, 32'h12345678, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0);
    tbl[5]  = mkv(1, 0, 32'h0E02802A, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0);       // header-looking, no sop
    tbl[6]  = mkv(1, 1, 32'h1E000100, CORR_EN, !CORR_EN, CORR_EN, 0, 4'h0, 0, 0, 16'h0);
    tbl[7]  = mkv(1, 1, 32'h1600032A, 1, 0, 0, 0, 4'h0, 0, 0, 16'h0);       // RAW8 WC=3
    tbl[8]  = mkv(0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 4'h0, 0, 0, 16'h0);
    tbl[9]  = mkv(1, 0, 32'hCCBBAA11, 0, 0, 0, 1, 4'h7, 1, 0, 16'h0);
    tbl[10] = mkv(1, 0, 32'h000000DD, 0, 0, 0, 0, 4'h0, 0, 1, 16'hDDCC);
    tbl[11] = mkv(1, 1, 32'h0E02002A, CORR_EN, !CORR_EN, CORR_EN, 0, 4'h0, 0, 0, 16'h0);

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].d);
      check($sformatf("vec%0d_hv", i), 32'(bus.hdr_valid), 32'(tbl[i].hv));
      check($sformatf("vec%0d_err", i), 32'(bus.hdr_err), 32'(tbl[i].err));
      check($sformatf("vec%0d_corr", i), 32'(bus.hdr_corrected), 32'(tbl[i].corr));
      check($sformatf("vec%0d_pv", i), 32'(bus.pay_valid), 32'(tbl[i].pv));
      check($sformatf("vec%0d_end", i), 32'(bus.pkt_end), 32'(tbl[i].pend));
      if (tbl[i].pv) begin
        check($sformatf("vec%0d_be", i), 32'(bus.pay_be), 32'(tbl[i].be));
        check($sformatf("vec%0d_last", i), 32'(bus.pay_last), 32'(tbl[i].last));
      end
      if (tbl[i].pend) check($sformatf("vec%0d_crc", i), 32'(bus.rx_crc), 32'(tbl[i].crc));
      if (tbl[i].hv && i == 11) check("vec11_wc", 32'(bus.hdr_wc), 32'd640);
    end
    do_reset("rst1");

    // RAW8 WC=640: 160 payload words then a CRC-only word
    pv_cnt = 0; end_cnt = 0;
    step(1, 1, 32'h0E02802A);
    check("a_hdr_dt", 32'(bus.hdr_dt), 32'h2A);
    check("a_hdr_wc", 32'(bus.hdr_wc), 32'd640);
    for (int i = 0; i < 161; i++) begin
      gap();
      w = $urandom;
      step(1, 0, w);
      if (i == 159) check("a_last", 32'(bus.pay_valid & bus.pay_last), 1);
      if (i == 160) begin
        check("a_end", 32'(bus.pkt_end), 1);
        check("a_crc", 32'(bus.rx_crc), 32'(w[15:0]));
      end
    end
    check("a_pv_cnt", pv_cnt, 160);
    check("a_end_cnt", end_cnt, 1);

    // abort: sop on payload word 10 carries an FS header
    pv_cnt = 0; end_cnt = 0;
    step(1, 1, 32'h0E02802A);
    for (int i = 0; i < 9; i++) step(1, 0, $urandom);
    step(1, 1, 32'h1A000100);
    check("b_abort", 32'(bus.pkt_abort), 1);
    check("b_hv", 32'(bus.hdr_valid), 1);
    check("b_dt", 32'(bus.hdr_dt), 32'(DT_FS));
    for (int i = 0; i < 5; i++) step(1, 0, $urandom);
    check("b_pv_cnt", pv_cnt, 9);
    check("b_end_cnt", end_cnt, 0);

    // reset in the middle of a packet
    step(1, 1, 32'h0E02802A);
    for (int i = 0; i < 3; i++) step(1, 0, $urandom);
    do_reset("rst2");
    pv_cnt = 0; end_cnt = 0;
    for (int i = 0; i < 4; i++) step(1, 0, $urandom);
    check("c_pv_cnt", pv_cnt, 0);
    check("c_end_cnt", end_cnt, 0);

    // WC=0: CRC-only word
    step(1, 1, mk_hdr(DT_RAW8, 2'd2, 16'd0));
    step(1, 0, 32'h1234BEEF);
    check("d_end", 32'(bus.pkt_end), 1);
    check("d_crc", 32'(bus.rx_crc), 32'hBEEF);
    check("d_pv", 32'(bus.pay_valid), 0);

    // word count boundaries
    step(1, 1, mk_hdr(DT_RAW10, 2'd1, 16'd8193));
    check("e_err_8193", 32'(bus.hdr_err), 1);
    step(1, 1, mk_hdr(DT_LS, 2'd3, 16'hFFFF));
    check("e_short_big", 32'(bus.hdr_valid & bus.hdr_short), 1);
    pv_cnt = 0; end_cnt = 0;
    step(1, 1, mk_hdr(DT_RAW8, 2'd0, 16'd8192));
    check("e_hv_8192", 32'(bus.hdr_valid), 1);
    for (int i = 0; i < 2049; i++) step(1, 0, $urandom);
    check("e_pv_cnt", pv_cnt, 2048);
    check("e_end_cnt", end_cnt, 1);

    // randomized packets
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        dt = 6'($urandom_range(0, 15));
        wc = 16'($urandom);
      end else begin
        case ($urandom_range(0, 2))
          0: dt = DT_RAW8;
          1: dt = DT_RAW10;
          default: dt = 6'($urandom_range(16, 63));
        endcase
        wc = ($urandom_range(0, 19) == 0) ? 16'($urandom_range(8193, 65535))
                                          : 16'($urandom_range(0, 40));
      end
      hw = mk_hdr(dt, 2'($urandom_range(0, 3)), wc) | (32'($urandom_range(0, 3)) << 30);
      case ($urandom_range(0, 9))
        0: hw ^= 32'h1 << $urandom_range(0, 23);
        1: hw ^= 32'h1 << $urandom_range(24, 29);
        2: hw ^= (32'h1 << $urandom_range(0, 11)) | (32'h1 << $urandom_range(12, 23));
        default: ;
      endcase
      nwords = (dt >= 6'h10 && int'(wc) <= MAX_WC) ? (int'(wc) + 5) / 4 : 2;
      if ($urandom_range(0, 9) == 0) nwords = $urandom_range(0, nwords);
      gap();
      step(1, 1, hw);
      for (int i = 0; i < nwords; i++) begin
        gap();
        step(1, 0, $urandom);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/csi_rx_packet_handler.md
Name: csi_rx_packet_handler

Overview:
- Sits directly downstream of the lane aligner/merger and consumes its 32-bit byte-aligned words; feeds the pixel unpacker.
- Checks and corrects each CSI-2 packet header using the existing csi_rx_hdr_ecc generator, then decodes DI/WC.
- Streams long-packet payload with byte enables, strips the trailing 2-byte CRC, and reports header and packet errors.

Parameters:
- MAX_WC, 16'd8192, largest accepted long-packet word count; larger WC is treated as a header error.

Ports:
- clk  in  1  pixel/byte clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_data  in  32  merged lane word; byte0 = [7:0] = first on wire.
- in_valid  in  1  in_data valid; gaps allowed anywhere.
- in_sop  in  1  with in_valid: this word is a packet header.
- hdr_valid  out  1  1-cycle pulse; header accepted.
- hdr_dt  out  6  data type.
- hdr_vc  out  2  virtual channel.
- hdr_wc  out  16  word count (short packet: data field).
- hdr_short  out  1  DT < 6'h10, qualified by hdr_valid.
- hdr_corrected  out  1  pulse; single-bit error fixed.
- hdr_err  out  1  pulse; uncorrectable header or WC > MAX_WC.
- pay_data  out  32  payload word.
- pay_valid  out  1  payload word valid.
- pay_be  out  4  byte enables; 4'hF except on the last word.
- pay_last  out  1  with pay_valid: final payload word.
- pkt_end  out  1  pulse; final CRC byte consumed.
- rx_crc  out  16  received CRC, {byte2nd,byte1st}; valid with pkt_end.
- pkt_abort  out  1  pulse; in_sop arrived mid-packet.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- All outputs are registered, so latency is 1 cycle from the accepted input word.
- Header fields: data[23:0] = in_data[23:0]; rx_ecc = in_data[29:24]; in_data[31:30] ignored.
- Syndrome S = ecc(data)[5:0] ^ rx_ecc.
  - S = 0: clean.
  - S equals the column of data bit k: flip bit k, pulse hdr_corrected.
  - S one-hot: error in the ECC byte; data used as received, pulse hdr_corrected.
  - Anything else: hdr_err, no hdr_valid, stay IDLE.
- Decoded fields: DI = data[7:0], dt = DI[5:0], vc = DI[7:6], wc = data[23:8].
- States:
  - IDLE: in_valid & in_sop → header check. Short packet → hdr_valid, stay IDLE. Long packet with wc ≤ MAX_WC → hdr_valid, load rem = wc + 2, go to BODY. in_valid without in_sop in IDLE is discarded.
  - BODY: each in_valid word consumes min(rem, 4) bytes. Payload bytes (first wc) go to pay_data with pay_be set per payload byte. CRC bytes go to rx_crc; a CRC split across two words is assembled.
  - pay_last is on the word holding payload byte wc-1.
  - pkt_end is on the word holding the last CRC byte, then return to IDLE.
  - wc mod 4 = 3: the last payload word carries CRC lo in byte3; CRC hi arrives next word.
  - wc = 0: no pay_valid at all; one CRC-only word.
- in_sop & in_valid in BODY: pulse pkt_abort, drop the remainder, and treat this word as a new header in the same cycle.
- in_valid low: hold state; no output pulses.
- Reset mid-packet: return to IDLE immediately, no pkt_end.

Optional Feature:
- CSI_RX_HDR_CORRECT_EN defined: single-bit correction as described above.
- Not defined: any nonzero S gives hdr_err, and hdr_corrected is tied 0.

Decomposition:
- csi_rx_pkg: DT constants (FS 6'h00, FE 6'h01, LS 6'h02, LE 6'h03, RAW8 6'h2A, RAW10 6'h2B), LONG_DT_MIN = 6'h10, the 24-entry syndrome column table, and the header struct (dt, vc, wc).
- Sub-module: reuse csi_rx_hdr_ecc for ecc(data); no new sub-module.

Test Plan:
- Header word 0x0E02802A (RAW8, VC0, WC 640), then 161 words → hdr_valid with dt=6'h2A, wc=640. Then 160 pay_valid with be=4'hF, pay_last on the 160th, pkt_end on the 161st, rx_crc = that word's [15:0].
- Word 0x0E02002A (bit15 flipped) → hdr_corrected=1, hdr_wc=640. Without CSI_RX_HDR_CORRECT_EN → hdr_err=1, no payload.
- Data bits 0 and 1 flipped (S = 6'h0C) → hdr_err; following words ignored until the next in_sop.
- Long packet with WC=3 → one word with pay_be=4'h7 and pay_last; CRC lo from byte3; next word byte0 is CRC hi, giving pkt_end.
- Short FS 0x??000100-style word with valid ECC → hdr_valid, hdr_short=1, no pay_valid; back-to-back FS/FE on consecutive cycles → both decoded.
- in_sop on payload word 10 of WC=640 → pkt_abort; the new header is decoded in the same cycle; no pkt_end for the aborted packet.
